mem_responder: RTL and testbench

//  Memory-side responder for the core's load/store port. It serves word/half/byte reads and writes

---
 rtl/mem_responder.sv | 169 ++++++++++++++++
 tb/tb_mem_responder.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder: word-organised RAM behind a valid/ready load/store port with
// WAIT_CYCLES programmable wait states.
// Build option: MEM_RESPONDER_MISALIGN_TRAP_EN faults misaligned half/word
// accesses; without it the low address bits are ignored for those sizes.
module mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] LIMIT = 33'(DEPTH_WORDS) << 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic          access;
  logic          fault;
  logic [AW-1:0] widx;
  logic [3:0]    be;
  logic [31:0]   wlane;
  logic [31:0]   word;
  logic [31:0]   byte_sh;
  logic [31:0]   load_data;

  // Decode of the latched request: fault, lane enables, store lanes, load data.
  always_comb begin
    fault     = ({1'b0, addr_q} >= LIMIT) || (size_q == 2'b11);
`ifdef MEM_RESPONDER_MISALIGN_TRAP_EN
    fault     = fault || ((size_q == 2'b01) && addr_q[0]) ||
                ((size_q == 2'b10) && (addr_q[1:0] != 2'b00));
`endif
    widx      = addr_q[AW+1:2];
    word      = mem_q[widx];
    byte_sh   = word >> {addr_q[1:0], 3'b000};
    be        = '0;
    wlane     = '0;
    load_data = '0;
    case (size_q)
      2'b00: begin
        be        = 4'b0001 << addr_q[1:0];
        wlane     = {4{wdata_q[7:0]}};
        load_data = {24'h0, byte_sh[7:0]};
      end
      2'b01: begin
        be        = addr_q[1] ? 4'b1100 : 4'b0011;
        wlane     = {2{wdata_q[15:0]}};
        load_data = {16'h0, (addr_q[1] ? word[31:16] : word[15:0])};
      end
      2'b10: begin
        be        = 4'b1111;
        wlane     = wdata_q;
        load_data = word;
      end
      default: begin
        be        = '0;
        wlane     = '0;
        load_data = '0;
      end
    endcase
  end

  // Every accepted request passes through ST_WAIT (even with WAIT_CYCLES==0)
  // so that rsp_valid rises WAIT_CYCLES+1 edges after the accept edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    we_d    = we_q;
    size_d  = size_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    access  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          we_d    = req_we;
          size_d  = req_size;
          wdata_d = req_wdata;
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          access  = 1'b1;
          err_d   = fault;
          rdata_d = (fault || we_q) ? '0 : load_data;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      size_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      size_q  <= size_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // RAM is never cleared; reset only suppresses a store that has not happened yet.
  always_ff @(posedge clk) begin
    if (reset && access && we_q && !fault) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem_q[widx][8*i +: 8] <= wlane[8*i +: 8];
        end
      end
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: three instances with WAIT_CYCLES 1, 3 and 0.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        reset     [3];
  logic        req_valid [3];
  logic        req_ready [3];
  logic [31:0] req_addr  [3];
  logic        req_we    [3];
  logic [1:0]  req_size  [3];
  logic [31:0] req_wdata [3];
  logic        rsp_valid [3];
  logic        rsp_ready [3];
  logic [31:0] rsp_rdata [3];
  logic        rsp_err   [3];

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_responder #(
      .DEPTH_WORDS(1024),
      .WAIT_CYCLES((g == 0) ? 1 : ((g == 1) ? 3 : 0))
    ) u_dut (
      .clk      (clk),
      .reset    (reset[g]),
      .req_valid(req_valid[g]),
      .req_ready(req_ready[g]),
      .req_addr (req_addr[g]),
      .req_we   (req_we[g]),
      .req_size (req_size[g]),
      .req_wdata(req_wdata[g]),
      .rsp_valid(rsp_valid[g]),
      .rsp_ready(rsp_ready[g]),
      .rsp_rdata(rsp_rdata[g]),
      .rsp_err  (rsp_err[g])
    );
  end

  typedef struct {
    logic        we;
    logic [1:0]  sz;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic we, input logic [1:0] sz, input logic [31:0] a,
                     input logic [31:0] wd, input logic [31:0] erd, input logic eer);
    vec_t v;
    v.we = we; v.sz = sz; v.addr = a; v.wdata = wd; v.exp_rd = erd; v.exp_err = eer;
    vecs.push_back(v);
  endtask

  // One full transaction with rsp_ready held high; lat counts edges from accept to rsp_valid.
  task automatic do_req(input int d, input logic we, input logic [1:0] sz,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat);
    int t;
    @(negedge clk);
    req_valid[d] = 1'b1; req_we[d] = we; req_size[d] = sz;
    req_addr[d] = a; req_wdata[d] = wd; rsp_ready[d] = 1'b1;
    t = 0;
    while (!req_ready[d] && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("accept_ready", 32'(req_ready[d]), 32'd1);
    @(posedge clk);
    #1;
    req_valid[d] = 1'b0;
    lat = 0;
    while (!rsp_valid[d] && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    rd = rsp_rdata[d];
    er = rsp_err[d];
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          cnt;

    for (int i = 0; i < 3; i++) begin
      reset[i] = 1'b0; req_valid[i] = 1'b0; req_we[i] = 1'b0; req_size[i] = 2'b00;
      req_addr[i] = '0; req_wdata[i] = '0; rsp_ready[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst%0d_req_ready", i), 32'(req_ready[i]), 32'd1);
      check($sformatf("rst%0d_rsp_valid", i), 32'(rsp_valid[i]), 32'd0);
      check($sformatf("rst%0d_rsp_rdata", i), rsp_rdata[i], 32'd0);
      check($sformatf("rst%0d_rsp_err", i), 32'(rsp_err[i]), 32'd0);
      reset[i] = 1'b1;
    end

    // we, size, addr, wdata, expected rdata, expected err
    add(1, 2'b10, 32'h10, 32'hDEADBEEF, 32'h0, 0);
    add(0, 2'b10, 32'h10, 32'h0, 32'hDEADBEEF, 0);
    add(1, 2'b10, 32'h10, 32'h11223344, 32'h0, 0);
    add(1, 2'b00, 32'h13, 32'h123456AA, 32'h0, 0);
    add(0, 2'b10, 32'h10, 32'h0, 32'hAA223344, 0);
    add(0, 2'b01, 32'h12, 32'h0, 32'h0000AA22, 0);
    add(0, 2'b00, 32'h11, 32'h0, 32'h00000033, 0);
    add(1, 2'b10, 32'h0, 32'h01020304, 32'h0, 0);
    add(0, 2'b10, 32'h1000, 32'h0, 32'h0, 1);
    add(1, 2'b10, 32'h1000, 32'hCAFEF00D, 32'h0, 1);
    add(0, 2'b10, 32'h0, 32'h0, 32'h01020304, 0);
    add(0, 2'b10, 32'h80000010, 32'h0, 32'h0, 1);
    add(0, 2'b11, 32'h10, 32'h0, 32'h0, 1);
    add(1, 2'b11, 32'h10, 32'hFFFFFFFF, 32'h0, 1);
    add(0, 2'b10, 32'h10, 32'h0, 32'hAA223344, 0);
    add(1, 2'b10, 32'h14, 32'h0, 32'h0, 0);
    add(1, 2'b01, 32'h16, 32'h1234BEEF, 32'h0, 0);
    add(0, 2'b10, 32'h14, 32'h0, 32'hBEEF0000, 0);
    add(0, 2'b00, 32'h17, 32'h0, 32'h000000BE, 0);
    add(0, 2'b01, 32'h14, 32'h0, 32'h00000000, 0);
    add(1, 2'b10, 32'hFFC, 32'h0A0B0C0D, 32'h0, 0);
    add(0, 2'b00, 32'hFFF, 32'h0, 32'h0000000A, 0);
    add(0, 2'b10, 32'hFFC, 32'h0, 32'h0A0B0C0D, 0);
    add(1, 2'b10, 32'h20, 32'h55667788, 32'h0, 0);
`ifdef MEM_RESPONDER_MISALIGN_TRAP_EN
    add(0, 2'b10, 32'h22, 32'h0, 32'h0, 1);
    add(0, 2'b01, 32'h13, 32'h0, 32'h0, 1);
    add(1, 2'b01, 32'h11, 32'h1234FFFF, 32'h0, 1);
    add(0, 2'b10, 32'h10, 32'h0, 32'hAA223344, 0);
`else
    add(0, 2'b10, 32'h22, 32'h0, 32'h55667788, 0);
    add(0, 2'b01, 32'h13, 32'h0, 32'h0000AA22, 0);
    add(1, 2'b01, 32'h11, 32'h1234FFFF, 32'h0, 0);
    add(0, 2'b10, 32'h10, 32'h0, 32'hAA22FFFF, 0);
`endif

    foreach (vecs[i]) begin
      do_req(0, vecs[i].we, vecs[i].sz, vecs[i].addr, vecs[i].wdata, rd, er, lat);
      check($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rd);
      check($sformatf("v%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
      check($sformatf("v%0d_latency", i), 32'(lat), 32'd2);
    end

    // Response held for 5 cycles with a stray request pulsed in the window.
    @(negedge clk);
    req_valid[0] = 1'b1; req_we[0] = 1'b0; req_size[0] = 2'b10;
    req_addr[0] = 32'h0; req_wdata[0] = '0; rsp_ready[0] = 1'b0;
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    cnt = 0;
    while (!rsp_valid[0] && cnt < 50) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check("hold_latency", 32'(cnt), 32'd2);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("hold%0d_valid", k), 32'(rsp_valid[0]), 32'd1);
      check($sformatf("hold%0d_rdata", k), rsp_rdata[0], 32'h01020304);
      check($sformatf("hold%0d_req_ready", k), 32'(req_ready[0]), 32'd0);
      if (k == 1) begin
        req_valid[0] = 1'b1; req_we[0] = 1'b1; req_wdata[0] = 32'hFFFFFFFF;
      end
      if (k == 3) req_valid[0] = 1'b0;
    end
    rsp_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    check("hold_release_valid", 32'(rsp_valid[0]), 32'd0);
    check("hold_release_ready", 32'(req_ready[0]), 32'd1);
    do_req(0, 1'b0, 2'b10, 32'h0, 32'h0, rd, er, lat);
    check("hold_no_second_access", rd, 32'h01020304);

    // WAIT_CYCLES=3: store dropped by reset during WAIT.
    do_req(1, 1'b1, 2'b10, 32'h20, 32'h0BADF00D, rd, er, lat);
    check("w3_store_latency", 32'(lat), 32'd4);
    do_req(1, 1'b0, 2'b10, 32'h20, 32'h0, rd, er, lat);
    check("w3_load_rdata", rd, 32'h0BADF00D);
    check("w3_load_latency", 32'(lat), 32'd4);
    @(negedge clk);
    req_valid[1] = 1'b1; req_we[1] = 1'b1; req_size[1] = 2'b10;
    req_addr[1] = 32'h20; req_wdata[1] = 32'h12345678;
    @(posedge clk);
    #1;
    req_valid[1] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("w3_in_wait_ready", 32'(req_ready[1]), 32'd0);
    reset[1] = 1'b0;
    @(posedge clk);
    #1;
    check("w3_rst_req_ready", 32'(req_ready[1]), 32'd1);
    check("w3_rst_rsp_valid", 32'(rsp_valid[1]), 32'd0);
    check("w3_rst_rsp_rdata", rsp_rdata[1], 32'd0);
    check("w3_rst_rsp_err", 32'(rsp_err[1]), 32'd0);
    @(negedge clk);
    reset[1] = 1'b1;
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid[1]) cnt++;
    end
    check("w3_no_late_rsp", 32'(cnt), 32'd0);
    do_req(1, 1'b0, 2'b10, 32'h20, 32'h0, rd, er, lat);
    check("w3_store_dropped", rd, 32'h0BADF00D);

    // WAIT_CYCLES=0 latency, and reset on the handshake edge.
    do_req(2, 1'b1, 2'b10, 32'h8, 32'h13579BDF, rd, er, lat);
    check("w0_store_latency", 32'(lat), 32'd1);
    do_req(2, 1'b0, 2'b10, 32'h8, 32'h0, rd, er, lat);
    check("w0_load_latency", 32'(lat), 32'd1);
    check("w0_load_rdata", rd, 32'h13579BDF);
    @(negedge clk);
    reset[2] = 1'b0; req_valid[2] = 1'b1; req_we[2] = 1'b1;
    req_size[2] = 2'b10; req_addr[2] = 32'h8; req_wdata[2] = 32'hFFFFFFFF;
    @(posedge clk);
    #1;
    reset[2] = 1'b1; req_valid[2] = 1'b0;
    cnt = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (rsp_valid[2]) cnt++;
    end
    check("w0_rst_hs_no_rsp", 32'(cnt), 32'd0);
    check("w0_rst_hs_ready", 32'(req_ready[2]), 32'd1);
    do_req(2, 1'b0, 2'b10, 32'h8, 32'h0, rd, er, lat);
    check("w0_rst_hs_dropped", rd, 32'h13579BDF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
